// File: rtl/ad9866_pkg.sv
// Shared types and helpers for the AD9866 receive path: sample/word widths,
// packer state encoding and sample sign extension.
package ad9866_pkg;

    localparam int AD9866_SAMPLE_W = 12;
    localparam int AD9866_WORD_W   = 32;

    typedef enum logic {
        EMPTY = 1'b0,
        HALF  = 1'b1
    } pack_state_t;

    function automatic logic [15:0] sext16(input logic [AD9866_SAMPLE_W-1:0] s);
        return {{(16 - AD9866_SAMPLE_W){s[AD9866_SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/ad9866_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; level comes from pointers one bit
// wider than the address, and a pop frees a slot for a push in the same cycle.
module ad9866_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_push_ok,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [AW:0]      w_level;
    logic             w_pop_ok;

    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == FULL_LVL);
    assign o_empty   = (w_level == '0);
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_push_ok = i_push & (~o_full | w_pop_ok);

    // Head reads as zero when empty so the output is clean out of reset.
    assign o_head = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (o_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (o_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/ad9866_rx_packer.sv
// Packs sample pairs into 32-bit words, buffers them and reports dropped words.
// AD9866_RX_OVF_COUNT_EN adds the saturating ovf_count port.  States: EMPTY | no sample held; HALF | low sample held.
module ad9866_rx_packer
    import ad9866_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [AD9866_SAMPLE_W-1:0]  rx_data,
    input  logic                        rx_enable,
    output logic [AD9866_WORD_W-1:0]    out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        overflow,
    input  logic                        clear_overflow
`ifdef AD9866_RX_OVF_COUNT_EN
    ,
    output logic [15:0]                 ovf_count
`endif
);

    pack_state_t                r_state;
    pack_state_t                w_state_nxt;
    logic                       w_latch;
    logic                       w_form;
    logic [AD9866_SAMPLE_W-1:0] r_low;
    logic [AD9866_WORD_W-1:0]   r_word;
    logic                       r_push;
    logic                       r_overflow;
    logic                       w_full;
    logic                       w_empty;
    logic                       w_push_ok;
    logic                       w_drop;

    always_ff @(posedge clock) begin
        if (!reset) r_state <= EMPTY;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_form      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (rx_enable) begin
                    w_latch     = 1'b1;
                    w_state_nxt = HALF;
                end
            end
            HALF: begin
                w_form      = rx_enable;
                w_state_nxt = EMPTY;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // The formed word is staged one cycle before it reaches the FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_low  <= '0;
            r_word <= '0;
            r_push <= 1'b0;
        end else begin
            r_push <= w_form;
            if (w_latch) r_low  <= rx_data;
            if (w_form)  r_word <= {sext16(rx_data), sext16(r_low)};
        end
    end

    ad9866_sync_fifo #(
        .WIDTH (AD9866_WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (r_push),
        .i_push_data (r_word),
        .i_pop       (out_ready),
        .o_head      (out_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_push_ok   (w_push_ok),
        .o_level     (level)
    );

    assign out_valid = ~w_empty;
    assign w_drop    = r_push & ~w_push_ok;

    // A drop outranks a coincident clear.
    always_ff @(posedge clock) begin
        if (!reset)              r_overflow <= 1'b0;
        else if (w_drop)         r_overflow <= 1'b1;
        else if (clear_overflow) r_overflow <= 1'b0;
    end

    assign overflow = r_overflow;

`ifdef AD9866_RX_OVF_COUNT_EN
    logic [15:0] r_ovf_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_ovf_count <= '0;
        end else if (w_drop) begin
            if (clear_overflow)              r_ovf_count <= 16'd1;
            else if (r_ovf_count != 16'hFFFF) r_ovf_count <= r_ovf_count + 16'd1;
        end else if (clear_overflow) begin
            r_ovf_count <= '0;
        end
    end

    assign ovf_count = r_ovf_count;
`else
    logic w_unused;
    assign w_unused = w_full;
`endif

endmodule

// File: tb/tb_ad9866_rx_packer.sv
// Randomised and directed bench for ad9866_rx_packer against a queue-based
// reference model; honours AD9866_RX_OVF_COUNT_EN when defined.
module tb_ad9866_rx_packer;

    localparam int DEPTH = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [11:0]   rx_data;
    logic          rx_enable;
    logic [31:0]   out_data;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] level;
    logic          overflow;
    logic          clear_overflow;
`ifdef AD9866_RX_OVF_COUNT_EN
    logic [15:0]   ovf_count;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mq[$];
    bit          m_have_low;
    logic [11:0] m_low;
    bit          m_pend_valid;
    logic [31:0] m_pend;
    bit          m_ovf;
    int          m_cnt;

    ad9866_rx_packer #(.DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .rx_data        (rx_data),
        .rx_enable      (rx_enable),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .level          (level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow)
`ifdef AD9866_RX_OVF_COUNT_EN
        ,
        .ovf_count      (ovf_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] sx(input logic [11:0] v);
        int x;
        x = int'(v);
        if (x >= 2048) x = x + 32'hF000;
        return 16'(x);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit pop;
        int sz;
        bit drop;
        if (!reset) begin
            mq.delete();
            m_have_low   = 0;
            m_pend_valid = 0;
            m_ovf        = 0;
            m_cnt        = 0;
            return;
        end
        sz   = mq.size();
        pop  = (sz != 0) && out_ready;
        drop = 0;
        if (pop) void'(mq.pop_front());
        if (m_pend_valid) begin
            if (sz < DEPTH || pop) mq.push_back(m_pend);
            else drop = 1;
        end
        if (clear_overflow) begin
            m_ovf = 0;
            m_cnt = 0;
        end
        if (drop) begin
            m_ovf = 1;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        m_pend_valid = 0;
        if (rx_enable) begin
            if (m_have_low) begin
                m_pend       = {sx(rx_data), sx(m_low)};
                m_pend_valid = 1;
                m_have_low   = 0;
            end else begin
                m_low      = rx_data;
                m_have_low = 1;
            end
        end else begin
            m_have_low = 0;
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("level", 32'(level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (mq.size() != 0) chk("data", out_data, mq[0]);
`ifdef AD9866_RX_OVF_COUNT_EN
        chk("ovf_count", 32'(ovf_count), 32'(m_cnt));
`endif
    endtask

    task automatic step(input bit en, input logic [11:0] d, input bit rdy, input bit clr);
        rx_enable      = en;
        rx_data        = d;
        out_ready      = rdy;
        clear_overflow = clr;
        @(posedge clock);
        model_update();
        @(negedge clock);
        check_all();
    endtask

    task automatic fill_full();
        for (int i = 0; i < 2 * DEPTH; i++) step(1, 12'($urandom), 0, 0);
        step(0, 12'h000, 0, 0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(0, 12'h000, 1, 0);
    endtask

    initial begin
        reset = 1'b0; rx_enable = 1'b1; rx_data = 12'hABC;
        out_ready = 1'b0; clear_overflow = 1'b0;
        @(negedge clock);
        step(1, 12'h5A5, 0, 0);
        step(1, 12'h123, 0, 0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        reset = 1'b1;

        // Basic pairs and latency
        step(1, 12'h001, 1, 0);
        step(1, 12'h7FF, 1, 0);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        step(1, 12'h800, 1, 0);
        chk("w0_valid", 32'(out_valid), 32'd1);
        chk("w0_data", out_data, 32'h07FF_0001);
        step(1, 12'hFFF, 1, 0);
        step(0, 12'h000, 1, 0);
        chk("w1_valid", 32'(out_valid), 32'd1);
        chk("w1_data", out_data, 32'hFFFF_F800);
        drain(2);

        // Burst break discards the odd sample
        step(1, 12'h555, 0, 0);
        step(1, 12'h00A, 0, 0);
        step(1, 12'h999, 0, 0);
        step(0, 12'h000, 0, 0);
        step(1, 12'h123, 0, 0);
        step(1, 12'hABC, 0, 0);
        step(0, 12'h000, 0, 0);
        chk("brk_level", 32'(level), 32'd2);
        chk("brk_w0", out_data, 32'h000A_0555);
        step(0, 12'h000, 1, 0);
        chk("brk_w1", out_data, 32'hFABC_0123);
        step(0, 12'h000, 1, 0);
        chk("brk_empty", 32'(out_valid), 32'd0);

        // Overflow: DEPTH+2 words with no consumer
        for (int i = 0; i < 2 * DEPTH + 4; i++) step(1, 12'($urandom), 0, 0);
        step(0, 12'h000, 0, 0);
        chk("ovf_level", 32'(level), 32'(DEPTH));
        chk("ovf_flag", 32'(overflow), 32'd1);
`ifdef AD9866_RX_OVF_COUNT_EN
        chk("ovf_cnt2", 32'(ovf_count), 32'd2);
`endif
        drain(DEPTH);
        chk("ovf_drained", 32'(level), 32'd0);
        step(0, 12'h000, 0, 1);
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Full with simultaneous pop and push
        fill_full();
        step(1, 12'h246, 0, 0);
        step(1, 12'h9BD, 0, 0);
        step(0, 12'h000, 1, 0);
        chk("fpp_level", 32'(level), 32'(DEPTH));
        chk("fpp_ovf", 32'(overflow), 32'd0);
        drain(DEPTH + 1);

        // Clear coincident with a drop, then an isolated clear
        fill_full();
        step(1, 12'h111, 0, 0);
        step(1, 12'h222, 0, 0);
        step(0, 12'h000, 0, 1);
        chk("clrdrop_ovf", 32'(overflow), 32'd1);
`ifdef AD9866_RX_OVF_COUNT_EN
        chk("clrdrop_cnt", 32'(ovf_count), 32'd1);
`endif
        step(0, 12'h000, 0, 1);
        chk("clr_ovf", 32'(overflow), 32'd0);
`ifdef AD9866_RX_OVF_COUNT_EN
        chk("clr_cnt", 32'(ovf_count), 32'd0);
`endif
        drain(DEPTH + 1);

        // Reset mid-operation with 5 words buffered and a half word held
        for (int i = 0; i < 11; i++) step(1, 12'($urandom), 0, 0);
        chk("mid_level5", 32'(level), 32'd5);
        reset = 1'b0;
        step(1, 12'h777, 0, 0);
        reset = 1'b1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        step(1, 12'h321, 0, 0);
        step(1, 12'h8AB, 0, 0);
        step(0, 12'h000, 0, 0);
        chk("mid_align", out_data, 32'hF8AB_0321);
        drain(2);

        // Random traffic: congested, then mostly draining
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, 12'($urandom),
                 (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 19) == 0);
        drain(DEPTH + 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
